// File: rtl/packet_fsm.sv
// ============================================================================
// Module   : packet_fsm
// Brief    : Head/body/tail framing tracker with done/err pulses and counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_fsm #(
   parameter int CNT_W  = 16,
   parameter int BEAT_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              head,
   input  logic              tail,
   input  logic              valid,
   output logic [1:0]        state,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [BEAT_W-1:0] beat_cnt,
   output logic [CNT_W-1:0]  pkt_cnt,
   output logic [BEAT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HEAD = 2'd1,
      S_DATA = 2'd2,
      S_TAIL = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic              err_q, err_d;
   logic              beat_inc;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
   logic [BEAT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      state_d  = state_q;
      err_d    = 1'b0;
      beat_inc = 1'b0;
      if (valid) begin
         case (state_q)
            S_IDLE: begin
               if (head) state_d = tail ? S_TAIL : S_HEAD;
               else      err_d   = 1'b1;
            end
            S_HEAD, S_DATA: begin
               // A head inside an open packet restarts framing from this beat.
               if (head) begin
                  err_d   = 1'b1;
                  state_d = tail ? S_TAIL : S_HEAD;
               end else begin
                  beat_inc = 1'b1;
                  state_d  = tail ? S_TAIL : S_DATA;
               end
            end
            default: begin
               if (head) state_d = tail ? S_TAIL : S_HEAD;
               else begin
                  state_d = S_IDLE;
                  err_d   = 1'b1;
               end
            end
         endcase
      end else if (state_q == S_TAIL) begin
         state_d = S_IDLE;
      end
   end

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (valid && head)
         beat_cnt_d = BEAT_W'(1);
      else if (beat_inc && (beat_cnt_q != {BEAT_W{1'b1}}))
         beat_cnt_d = beat_cnt_q + BEAT_W'(1);
   end

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (valid && (state_d == S_TAIL))
         pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_d && (err_cnt_q != {BEAT_W{1'b1}}))
         err_cnt_d = err_cnt_q + BEAT_W'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         err_q      <= 1'b0;
         beat_cnt_q <= '0;
         pkt_cnt_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         beat_cnt_q <= beat_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign state    = state_q;
   assign busy     = (state_q == S_HEAD) || (state_q == S_DATA);
   assign done     = (state_q == S_TAIL);
   assign err      = err_q;
   assign beat_cnt = beat_cnt_q;
   assign pkt_cnt  = pkt_cnt_q;
   assign err_cnt  = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_packet_fsm.sv
// ============================================================================
// Module   : tb_packet_fsm
// Brief    : Self-checking bench for packet_fsm: reference model plus directed
//            framing, saturation, wrap and async-reset scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_packet_fsm;

   localparam int BMAX = 255;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        head  = 1'b0;
   logic        tail  = 1'b0;
   logic        valid = 1'b0;
   logic [1:0]  state;
   logic        busy, done, err;
   logic [7:0]  beat_cnt;
   logic [15:0] pkt_cnt;
   logic [7:0]  err_cnt;

   int tests = 0;
   int fails = 0;

   packet_fsm #(.CNT_W(16), .BEAT_W(8)) dut (
      .clock    (clock),
      .reset    (reset),
      .head     (head),
      .tail     (tail),
      .valid    (valid),
      .state    (state),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .beat_cnt (beat_cnt),
      .pkt_cnt  (pkt_cnt),
      .err_cnt  (err_cnt)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: "open" means a packet has started and not yet ended.
   int m_state = 0;
   int m_beat  = 0;
   int m_pkt   = 0;
   int m_errc  = 0;
   int m_err   = 0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_state <= 0; m_beat <= 0; m_pkt <= 0; m_errc <= 0; m_err <= 0;
      end else if (valid) begin : upd
         bit open_pkt;
         bit bad;
         int nxt;
         open_pkt = (m_state == 1) || (m_state == 2);
         if (head) begin
            nxt = tail ? 3 : 1;
            bad = open_pkt;
         end else if (open_pkt) begin
            nxt = tail ? 3 : 2;
            bad = 1'b0;
         end else begin
            nxt = 0;
            bad = 1'b1;
         end
         m_state <= nxt;
         m_err   <= bad ? 1 : 0;
         if (head)          m_beat <= 1;
         else if (open_pkt) m_beat <= (m_beat < BMAX) ? m_beat + 1 : BMAX;
         if (nxt == 3)      m_pkt  <= (m_pkt + 1) % 65536;
         if (bad)           m_errc <= (m_errc < BMAX) ? m_errc + 1 : BMAX;
      end else begin
         if (m_state == 3) m_state <= 0;
         m_err <= 0;
      end
   end

   always @(negedge clock) begin
      check("state",    state,    m_state);
      check("busy",     busy,     (m_state == 1 || m_state == 2) ? 1 : 0);
      check("done",     done,     (m_state == 3) ? 1 : 0);
      check("err",      err,      m_err);
      check("beat_cnt", beat_cnt, m_beat);
      check("pkt_cnt",  pkt_cnt,  m_pkt);
      check("err_cnt",  err_cnt,  m_errc);
   end

   task automatic beat(input logic v, input logic h, input logic t);
      @(negedge clock);
      valid = v; head = h; tail = t;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      valid = 1'b0;
      #2 reset = 1'b0;
      @(negedge clock);
      #2 reset = 1'b1;
   endtask

   initial begin
      #1 reset = 1'b0;
      // Reset held low with random inputs: everything stays zero.
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         valid = 1'(($urandom >> 3) & 1); head = 1'($urandom & 1); tail = 1'(($urandom >> 1) & 1);
      end
      @(posedge clock); #1;
      check("rst_state", state, 0);
      check("rst_cnts",  {beat_cnt, pkt_cnt, err_cnt}, 0);
      @(negedge clock);
      valid = 1'b0;
      #2 reset = 1'b1;
      beat(1'b0, 1'b1, 1'b1);
      beat(1'b0, 1'b0, 1'b1);
      check("post_rst_idle", state, 0);

      // Normal packet with a stall.
      beat(1'b1, 1'b1, 1'b0); check("n_head", state, 1); check("n_busy", busy, 1);
      beat(1'b1, 1'b0, 1'b0); check("n_d1", state, 2);
      beat(1'b1, 1'b0, 1'b0); check("n_d2", state, 2);
      for (int i = 0; i < 5; i++) beat(1'b0, 1'($urandom & 1), 1'(($urandom >> 1) & 1));
      check("n_stall", state, 2);
      beat(1'b1, 1'b0, 1'b1); check("n_tail", state, 3); check("n_done", done, 1);
      check("n_beat", beat_cnt, 4); check("n_pkt", pkt_cnt, 1); check("n_err", err, 0);
      beat(1'b0, 1'b0, 1'b0); check("n_idle", state, 0);

      // Back-to-back packets.
      do_reset();
      beat(1'b1, 1'b1, 1'b0); check("b_s1", state, 1);
      beat(1'b1, 1'b0, 1'b1); check("b_s2", state, 3);
      beat(1'b1, 1'b1, 1'b0); check("b_s3", state, 1);
      beat(1'b1, 1'b1, 1'b1); check("b_s4", state, 3); check("b_err", err, 1);
      check("b_pkt", pkt_cnt, 2); check("b_errc", err_cnt, 1);

      // Illegal beats.
      do_reset();
      beat(1'b1, 1'b0, 1'b1); check("i_idle", state, 0); check("i_err", err, 1);
      check("i_errc", err_cnt, 1);
      beat(1'b0, 1'b0, 1'b0); check("i_err_clr", err, 0);
      beat(1'b1, 1'b1, 1'b0);
      beat(1'b1, 1'b0, 1'b0);
      beat(1'b1, 1'b1, 1'b0); check("i_restart", state, 1); check("i_err2", err, 1);
      check("i_beat", beat_cnt, 1); check("i_errc2", err_cnt, 2);

      // Beat counter saturation.
      do_reset();
      beat(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 300; i++) beat(1'b1, 1'b0, 1'b0);
      check("s_beat", beat_cnt, 255); check("s_state", state, 2);

      // Packet counter wrap with single-beat packets.
      do_reset();
      for (int i = 0; i < 65535; i++) beat(1'b1, 1'b1, 1'b1);
      check("w_pre", pkt_cnt, 65535);
      beat(1'b1, 1'b1, 1'b1);
      check("w_wrap", pkt_cnt, 0); check("w_errc", err_cnt, 0);

      // Asynchronous reset mid-packet.
      do_reset();
      beat(1'b1, 1'b1, 1'b0);
      beat(1'b1, 1'b0, 1'b0);
      beat(1'b1, 1'b0, 1'b0);
      check("a_pre", state, 2);
      @(negedge clock);
      valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("a_state", state, 0); check("a_beat", beat_cnt, 0);
      check("a_pkt", pkt_cnt, 0); check("a_busy", busy, 0);
      @(negedge clock);
      #2 reset = 1'b1;

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         valid = ($urandom_range(0, 99) < 70);
         head  = ($urandom_range(0, 99) < 30);
         tail  = ($urandom_range(0, 99) < 30);
         if ($urandom_range(0, 499) == 0) begin
            #2 reset = 1'b0;
            #1 reset = 1'b1;
         end
      end
      @(negedge clock);
      valid = 1'b0;
      repeat (2) @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/packet_fsm.md
# packet_fsm

Packet-framing state machine that tracks head/body/tail delimiters on a single-beat-per-cycle stream qualified by `valid`. It reports the current framing state, one-cycle `done` and `err` pulses, and running beat, packet and error counts. It sits beside a streaming datapath as a protocol monitor and framing tracker; it does not touch data.

## Interface
Parameters:
- `CNT_W`, default 16: width of the packet counter.
- `BEAT_W`, default 8: width of the beat and error counters.

Ports:
- `clock`  in  1  — single clock; all state updates on its rising edge.
- `reset`  in  1  — one clock; reset is asynchronous and active-low. Name `reset`; asserted when 0.
- `head`  in  1  — current beat is a packet head; meaningful only when `valid`=1.
- `tail`  in  1  — current beat is a packet tail; meaningful only when `valid`=1.
- `valid`  in  1  — a beat is present this cycle.
- `state`  out  2  — IDLE=0, HEAD=1, DATA=2, TAIL=3.
- `busy`  out  1  — 1 when `state` is HEAD or DATA.
- `done`  out  1  — 1 when `state` is TAIL.
- `err`  out  1  — one-cycle pulse, registered, following an illegal beat.
- `beat_cnt`  out  BEAT_W  — beats in the current/last packet, saturating.
- `pkt_cnt`  out  CNT_W  — completed packets, wrapping.
- `err_cnt`  out  BEAT_W  — illegal beats, saturating at all-ones.

## Operation
- Inputs are sampled only on rising `clock`. A "beat" means `valid`=1 at the edge. When `valid`=0, `head` and `tail` are ignored.
- Transitions on a beat (h=`head`, t=`tail`):
  - IDLE:
    - h → HEAD, or TAIL if t also set (single-beat packet).
    - !h & t → IDLE, err.
    - !h & !t → IDLE, err (body outside a packet).
  - HEAD or DATA:
    - t & !h → TAIL.
    - h (with or without t) → err; restart: HEAD if !t, TAIL if t.
    - !h & !t → DATA.
  - TAIL:
    - h & !t → HEAD.
    - h & t → TAIL.
    - !h → IDLE, err.
- Transitions with no beat:
  - HEAD and DATA hold.
  - TAIL → IDLE.
  - IDLE holds.
- `beat_cnt`:
  - Loaded with 1 on any beat with h=1.
  - Incremented on a non-head beat taken in HEAD or DATA, including the tail beat.
  - Saturates at 2^BEAT_W−1 and otherwise holds.
- `pkt_cnt`: increments by 1 on every transition into TAIL, including TAIL→TAIL; wraps modulo 2^CNT_W.
- `err_cnt`: increments on every err beat; saturates.
- `busy` and `done` decode registered `state` combinationally. `err` is a register.

## Timing
- Reset (asynchronous, `reset`=0): `state`=IDLE, `busy`=0, `done`=0, `err`=0, all counters 0. These hold while `reset`=0.
- Release is synchronous in effect: the first edge with `reset`=1 evaluates normally.
- Reset mid-packet aborts the packet; counters are not preserved.
- Latency: a beat at edge N is reflected in `state`, `busy`, `done`, `err` and the counters after edge N, i.e. one cycle.
- `done` is high exactly one cycle per packet unless back-to-back tails occur. `err` is high exactly one cycle per illegal beat; consecutive illegal beats keep it high.
- No handshake or backpressure: every beat is consumed.

## Test plan
- Reset values: drive `reset`=0 with random `head`/`tail`/`valid` → `state`=0, all outputs 0 throughout; deassert → still IDLE until the first beat.
- Normal packet, stalls included:
  - Stimulus: beats h; then 2 body beats; then `valid`=0 for 5 cycles; then t.
  - States → HEAD, DATA, DATA (held through the stall), TAIL, IDLE.
  - Final counters: `beat_cnt`=4, `pkt_cnt`=1, `err`=0.
- Back-to-back packets:
  - Stimulus: h, t, h (from TAIL), then h&t.
  - States → HEAD, TAIL, HEAD, TAIL.
  - `pkt_cnt`=2. The second h&t beat counts as an error restart: `err_cnt`=1.
- Illegal beats:
  - Tail in IDLE → stays IDLE, `err` pulse, `err_cnt`=1.
  - Head in DATA → HEAD, `err` pulse, `beat_cnt`=1.
- Saturation and wrap:
  - 300 body beats after a head → `beat_cnt`=255.
  - With `pkt_cnt` preset near limit via 65536 single-beat packets, `pkt_cnt` wraps to 0.
- Async reset mid-packet: assert `reset`=0 between edges while in DATA → `state`=0 and counters 0 immediately, without waiting for an edge.
